// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// State encodings match the FIFO side so both can decode the same busy/idle values.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_W = 17;

    // Grantee index width; a single producer still needs one bit.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return (max_burst >= 1) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_id, wrapping,
// so last_id itself is considered last.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic             found,
    output logic [ID_W-1:0]  id
);

    logic [ID_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        id    = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_id) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port between N_REQ producers.
//   state    | meaning
//   ST_IDLE  | no grant; picking a requester takes one cycle, no beat moves
//   ST_GRANT | gnt_id owns the write port until its last beat or MAX_BURST beats
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = id_width(N_REQ),
    parameter int CNT_W     = cnt_width(MAX_BURST)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    full,
    output logic                    w_en,
    output logic [DATA_W-1:0]       w_data,
    output logic [ID_W-1:0]         gnt_id,
    output logic                    busy
);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_last;
    logic [CNT_W-1:0]  beat_cnt;

    logic              granted;
    logic              release_grant;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   pick_base;
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign granted = (state == ST_GRANT);
    assign busy    = granted;

    // On release the search restarts after the id being released, which is the
    // value rr_last is about to take; in IDLE it restarts after rr_last.
    assign pick_base = granted ? gnt_id : rr_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (req_valid),
        .last_id (pick_base),
        .found   (pick_found),
        .id      (pick_id)
    );

    always_comb begin
        req_ready = '0;
        w_en      = 1'b0;
        w_data    = '0;
        if (granted) begin
            req_ready[gnt_id] = ~full;
            w_en              = req_valid[gnt_id] & ~full;
            w_data            = data_arr[gnt_id];
        end
    end

    assign release_grant = w_en &
                           (req_last[gnt_id] | (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_id   <= '0;
            rr_last  <= ID_W'(N_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state    <= ST_GRANT;
                        gnt_id   <= pick_id;
                        beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        rr_last  <= gnt_id;
                        beat_cnt <= '0;
                        if (pick_found) begin
                            gnt_id <= pick_id;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (w_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_W=17, MAX_BURST=8).
// Each step compares {busy, w_en, gnt_id, req_ready, w_data} against hand-derived values.
module tb_fifo_wr_arbiter;
    import fifo_wr_arbiter_pkg::*;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 17;
    localparam int MAX_BURST = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ-1:0]        req_last = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic                    full = 1'b0;
    logic [N_REQ-1:0]        req_ready;
    logic                    w_en;
    logic [DATA_W-1:0]       w_data;
    logic [1:0]              gnt_id;
    logic                    busy;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .w_en      (w_en),
        .w_data    (w_data),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] dv(input int i, input int k);
        return DATA_W'(i * 4096 + k);
    endfunction

    task automatic set_data(input int i, input int k);
        req_data[i*DATA_W +: DATA_W] = dv(i, k);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [24:0] got, exp;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        full      = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_data(i, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        exp = '0;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL reset_held: got=%h exp=%h", got, exp);
        end
        rst = 1'b0;
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL reset_idle: got=%h exp=%h", got, exp);
        end
        @(posedge clk);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        exp = {1'b1, 1'b1, 2'd0, 4'b0001, dv(0, 0)};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL reset_first_grant: got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_rr_fairness;
        logic [24:0] got, exp;
        int g;
        do_reset();
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < N_REQ; i++) set_data(i, 0);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        exp = '0;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL rr_idle: got=%h exp=%h", got, exp);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            g   = c % 4;
            got = {busy, w_en, gnt_id, req_ready, w_data};
            exp = {1'b1, 1'b1, 2'(g), 4'(1 << g), dv(g, 0)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL rr_cycle%0d: got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_burst_cap;
        logic [24:0] got, exp;
        int k, k2, k3, g, kg;
        // Lone producer: cap releases and re-grants with no bubble.
        do_reset();
        req_valid = 4'b0100;
        k = 0;
        set_data(2, 0);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        exp = '0;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL burst_idle: got=%h exp=%h", got, exp);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            set_data(2, k);
            req_last[2] = (k == 19);
            #1;
            got = {busy, w_en, gnt_id, req_ready, w_data};
            exp = {1'b1, 1'b1, 2'd2, 4'b0100, dv(2, k)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL burst_alone_c%0d: got=%h exp=%h", c, got, exp);
            end
            k++;
        end
        // Competing producer makes each 8-beat cap visible as a grant change.
        do_reset();
        req_valid = 4'b1100;
        k2 = 0;
        k3 = 0;
        set_data(2, 0);
        set_data(3, 0);
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            set_data(2, k2);
            set_data(3, k3);
            #1;
            g   = ((c / MAX_BURST) % 2 == 0) ? 2 : 3;
            kg  = (g == 2) ? k2 : k3;
            got = {busy, w_en, gnt_id, req_ready, w_data};
            exp = {1'b1, 1'b1, 2'(g), 4'(1 << g), dv(g, kg)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL burst_shared_c%0d: got=%h exp=%h", c, got, exp);
            end
            if (g == 2) k2++;
            else        k3++;
        end
    endtask

    task automatic test_backpressure;
        logic [24:0] got, exp;
        int k1, k3, g, kg;
        do_reset();
        req_valid = 4'b1010;
        k1 = 0;
        k3 = 0;
        set_data(1, 0);
        set_data(3, 0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            full = (c >= 5 && c <= 7);
            set_data(1, k1);
            set_data(3, k3);
            #1;
            g   = (c <= 10) ? 1 : 3;
            kg  = (g == 1) ? k1 : k3;
            got = {busy, w_en, gnt_id, req_ready, w_data};
            if (full) exp = {1'b1, 1'b0, 2'd1, 4'b0000, dv(1, k1)};
            else      exp = {1'b1, 1'b1, 2'(g), 4'(1 << g), dv(g, kg)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL backpressure_c%0d: got=%h exp=%h", c, got, exp);
            end
            if (!full) begin
                if (g == 1) k1++;
                else        k3++;
            end
        end
        full = 1'b0;
    endtask

    task automatic test_grantee_stall;
        logic [24:0] got, exp;
        int k1, g, kg;
        logic stall;
        do_reset();
        req_valid = 4'b1010;
        k1 = 0;
        set_data(1, 0);
        set_data(3, 0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            stall        = (c >= 1 && c <= 4);
            req_valid[1] = !stall;
            req_last[1]  = (k1 == 2);
            set_data(1, k1);
            #1;
            g   = (c <= 6) ? 1 : 3;
            kg  = (g == 1) ? k1 : 0;
            got = {busy, w_en, gnt_id, req_ready, w_data};
            exp = {1'b1, !stall, 2'(g), 4'(1 << g), dv(g, kg)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL stall_c%0d: got=%h exp=%h", c, got, exp);
            end
            if (g == 1 && !stall) k1++;
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [24:0] got, exp;
        do_reset();
        req_valid = 4'b0001;
        set_data(0, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            set_data(0, k);
            #1;
            got = {busy, w_en, gnt_id, req_ready, w_data};
            exp = {1'b1, 1'b1, 2'd0, 4'b0001, dv(0, k)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL midrst_beat%0d: got=%h exp=%h", k, got, exp);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        exp = '0;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL midrst_truncate: got=%h exp=%h", got, exp);
        end
        rst       = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < N_REQ; i++) set_data(i, 0);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL midrst_idle: got=%h exp=%h", got, exp);
        end
        @(posedge clk);
        #1;
        got = {busy, w_en, gnt_id, req_ready, w_data};
        exp = {1'b1, 1'b1, 2'd0, 4'b0001, dv(0, 0)};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL midrst_regrant: got=%h exp=%h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_burst_cap();
        test_backpressure();
        test_grantee_stall();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
